// File: rtl/vector_pkg.sv
// Shared constants and types for the vector memory sequencer.
// Element geometry, FSM state type and VLD/VST opcodes.
package vector_pkg;

  localparam int ELEMS  = 16;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int VEC_W  = ELEMS * DATA_W;
  localparam int IDX_W  = $clog2(ELEMS);

  localparam logic [3:0] OP_VLD = 4'b0100;
  localparam logic [3:0] OP_VST = 4'b0101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_RD,
    S_DONE
  } vmu_state_t;

  function automatic logic is_vst(
    input logic [3:0] op
  );
    return op == OP_VST;
  endfunction

endpackage

// File: rtl/vector_mem_unit.sv
// Serialises 16-element vector loads/stores onto a word memory port.
// Ports: start/is_store/base_addr/st_vec in, busy/done/ld_vec out, mem_* port.
module vector_mem_unit
  import vector_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_store,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [VEC_W-1:0]  st_vec,
  output logic              busy,
  output logic              done,
  output logic [VEC_W-1:0]  ld_vec,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid
);

  vmu_state_t        r_state;
  vmu_state_t        w_next;
  logic [IDX_W-1:0]  r_idx;
  logic              r_is_store;
  logic [ADDR_W-1:0] r_base;
  logic [VEC_W-1:0]  r_st_vec;
  logic [VEC_W-1:0]  r_ld_vec;

  logic w_idle;
  logic w_accept;
  logic w_last;
  logic w_hs;
  logic w_rd;

  assign w_idle   = (r_state == S_IDLE) ||
                    (r_state == S_DONE);
  assign w_accept = w_idle && start;
  assign w_last   = r_idx == IDX_W'(ELEMS - 1);
  assign w_hs     = (r_state == S_REQ) && mem_gnt;
  assign w_rd     = (r_state == S_WAIT_RD) &&
                    mem_rvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (start) w_next = S_REQ;
        else       w_next = S_IDLE;
      end
      S_REQ: begin
        if (mem_gnt) begin
          if (!r_is_store) w_next = S_WAIT_RD;
          else if (w_last) w_next = S_DONE;
        end
      end
      S_WAIT_RD: begin
        if (mem_rvalid) begin
          if (w_last) w_next = S_DONE;
          else        w_next = S_REQ;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Loads advance the index on data return, stores on grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_is_store <= 1'b0;
      r_base     <= '0;
      r_st_vec   <= '0;
      r_ld_vec   <= '0;
    end else begin
      if (w_accept) begin
        r_idx      <= '0;
        r_is_store <= is_store;
        r_base     <= base_addr;
        r_st_vec   <= st_vec;
      end
      if (w_hs && r_is_store && !w_last) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_rd) begin
        r_ld_vec[DATA_W*r_idx +: DATA_W] <= mem_rdata;
        if (!w_last) r_idx <= r_idx + 1'b1;
      end
    end
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (r_state)
      S_REQ: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_we   = r_is_store;
        mem_addr = r_base + ADDR_W'(r_idx);
        if (r_is_store) begin
          mem_wdata = r_st_vec[DATA_W*r_idx +: DATA_W];
        end
      end
      S_WAIT_RD: busy = 1'b1;
      S_DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign ld_vec = r_ld_vec;

endmodule

// File: tb/tb_vector_mem_unit.sv
// Self-checking bench for vector_mem_unit.
// Reactive memory model plus directed and randomized vector operations.
module tb_vector_mem_unit;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         is_store = 1'b0;
  logic [15:0]  base_addr = '0;
  logic [255:0] st_vec = '0;
  logic         busy, done;
  logic [255:0] ld_vec;
  logic         mem_req, mem_we;
  logic [15:0]  mem_addr, mem_wdata;
  logic         mem_gnt = 1'b0;
  logic [15:0]  mem_rdata = '0;
  logic         mem_rvalid = 1'b0;

  vector_mem_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .is_store(is_store), .base_addr(base_addr),
    .st_vec(st_vec), .busy(busy), .done(done),
    .ld_vec(ld_vec), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;

  int gnt_pct = 100;
  int rv_pct = 100;
  bit noise = 0;
  int stalls = 0;
  int rd_cnt = 0;
  logic [31:0] wlog[$];
  logic [15:0] mem [0:65535];

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // Memory responder: decides gnt/rvalid on the falling edge.
  bit          pending = 0;
  logic [15:0] pdata = '0;
  bit          prev_stall = 0;
  logic [15:0] prev_addr = '0;
  logic [15:0] prev_wdata = '0;
  logic        prev_we = 1'b0;

  initial begin
    for (int a = 0; a < 65536; a++)
      mem[a] = 16'(a) ^ 16'h5555;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      mem_gnt = 0;
      mem_rvalid = 0;
      pending = 0;
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_req", 256'(mem_req), 256'(1));
        chk("stall_addr", 256'(mem_addr), 256'(prev_addr));
        chk("stall_wdata", 256'(mem_wdata), 256'(prev_wdata));
        chk("stall_we", 256'(mem_we), 256'(prev_we));
      end
      if (pending)
        chk("one_outstanding", 256'(mem_req), 256'(0));
      mem_rvalid = 0;
      mem_rdata = 16'($urandom);
      if (pending) begin
        if (int'($urandom_range(99)) < rv_pct) begin
          mem_rvalid = 1;
          mem_rdata = pdata;
          pending = 0;
          rd_cnt++;
        end
      end else if (noise && mem_req) begin
        mem_rvalid = 1'($urandom);
      end
      mem_gnt = mem_req &&
                (int'($urandom_range(99)) < gnt_pct);
      if (noise && !mem_req) mem_gnt = 1'($urandom);
      if (mem_req && mem_gnt) begin
        if (mem_we) begin
          mem[mem_addr] = mem_wdata;
          wlog.push_back({mem_addr, mem_wdata});
        end else begin
          pending = 1;
          pdata = mem[mem_addr];
        end
      end
      prev_stall = mem_req && !mem_gnt;
      prev_addr = mem_addr;
      prev_wdata = mem_wdata;
      prev_we = mem_we;
      if (prev_stall) stalls++;
    end
  end

  // Call at a falling edge while the DUT is idle or done.
  task automatic launch(input logic st,
                        input logic [15:0] b,
                        input logic [255:0] v);
    is_store = st;
    base_addr = b;
    st_vec = v;
    start = 1;
    wlog.delete();
    stalls = 0;
    rd_cnt = 0;
  endtask

  task automatic wait_done(output int cyc,
                           output int bcnt);
    cyc = 0;
    bcnt = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (busy) bcnt++;
      if (noise && busy) begin
        start = 1'($urandom);
        is_store = 1'($urandom);
        base_addr = 16'($urandom);
        st_vec = {8{$urandom}};
      end else begin
        start = 0;
      end
    end while (!done && cyc < 3000);
    chk("done_seen", 256'(done), 256'(1));
  endtask

  task automatic chk_writes(input string tag,
                            input logic [15:0] b,
                            input logic [255:0] v);
    chk({tag, "_nwrites"}, 256'(wlog.size()), 256'(16));
    for (int i = 0; i < 16 && i < wlog.size(); i++) begin
      chk({tag, "_addr"}, 256'(wlog[i][31:16]),
          256'(16'(b + 16'(i))));
      chk({tag, "_data"}, 256'(wlog[i][15:0]),
          256'(v[16*i +: 16]));
    end
  endtask

  logic [255:0] v, exp, first;
  logic [15:0]  b;
  int cyc, bcnt;
  logic st;

  initial begin
    #1;
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_req", 256'(mem_req), 256'(0));
    chk("rst_we", 256'(mem_we), 256'(0));
    chk("rst_addr", 256'(mem_addr), 256'(0));
    chk("rst_wdata", 256'(mem_wdata), 256'(0));
    chk("rst_ldvec", ld_vec, 256'(0));
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // Store, grant always high.
    for (int i = 0; i < 16; i++) v[16*i +: 16] = 16'hA000 + 16'(i);
    launch(1, 16'h0100, v);
    wait_done(cyc, bcnt);
    chk("st_cycles", 256'(cyc), 256'(17));
    chk("st_busy_cycles", 256'(bcnt), 256'(16));
    chk_writes("st", 16'h0100, v);
    chk("st_ldvec_untouched", ld_vec, 256'(0));
    @(negedge clk);
    chk("done_one_cycle", 256'(done), 256'(0));

    // Load, grant high, rvalid one cycle later.
    launch(0, 16'h0200, '0);
    wait_done(cyc, bcnt);
    for (int i = 0; i < 16; i++)
      exp[16*i +: 16] = (16'h0200 + 16'(i)) ^ 16'h5555;
    chk("ld_cycles", 256'(cyc), 256'(33));
    chk("ld_vec", ld_vec, exp);
    chk("ld_no_writes", 256'(wlog.size()), 256'(0));
    @(negedge clk);

    // Wrapping store with random grant stalls.
    gnt_pct = 50;
    v = {8{$urandom}};
    launch(1, 16'hFFF8, v);
    wait_done(cyc, bcnt);
    chk("wrap_cycles", 256'(cyc), 256'(17 + stalls));
    chk_writes("wrap", 16'hFFF8, v);
    @(negedge clk);

    // Clean load of the wrapped region, then a noisy one.
    gnt_pct = 100;
    launch(0, 16'hFFF8, '0);
    wait_done(cyc, bcnt);
    first = ld_vec;
    chk("wrap_ld_clean", first, v);
    @(negedge clk);
    gnt_pct = 50;
    rv_pct = 50;
    noise = 1;
    launch(0, 16'hFFF8, '0);
    wait_done(cyc, bcnt);
    noise = 0;
    chk("wrap_ld_noisy", ld_vec, v);
    chk("noise_no_writes", 256'(wlog.size()), 256'(0));
    @(negedge clk);

    // Reset in the middle of a load.
    gnt_pct = 100;
    rv_pct = 100;
    launch(0, 16'h0300, '0);
    cyc = 0;
    do begin
      @(negedge clk);
      start = 0;
      cyc++;
    end while (rd_cnt < 5 && cyc < 200);
    chk("five_returned", 256'(rd_cnt), 256'(5));
    @(negedge clk);
    #1 rst_n = 0;
    #1;
    chk("mid_rst_busy", 256'(busy), 256'(0));
    chk("mid_rst_req", 256'(mem_req), 256'(0));
    chk("mid_rst_ldvec", ld_vec, 256'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    launch(0, 16'h0300, '0);
    wait_done(cyc, bcnt);
    for (int i = 0; i < 16; i++)
      exp[16*i +: 16] = (16'h0300 + 16'(i)) ^ 16'h5555;
    chk("post_rst_cycles", 256'(cyc), 256'(33));
    chk("post_rst_ld", ld_vec, exp);
    @(negedge clk);

    // Back-to-back store then load in the done cycle.
    v = {8{$urandom}};
    launch(1, 16'h1234, v);
    wait_done(cyc, bcnt);
    chk_writes("b2b_st", 16'h1234, v);
    launch(0, 16'h1234, '0);
    wait_done(cyc, bcnt);
    chk("b2b_ld_cycles", 256'(cyc), 256'(33));
    chk("b2b_ld", ld_vec, v);
    @(negedge clk);

    // Random operations against the memory model.
    gnt_pct = 60;
    rv_pct = 60;
    for (int r = 0; r < 6; r++) begin
      st = 1'($urandom);
      b = 16'($urandom);
      v = {8{$urandom}};
      for (int i = 0; i < 16; i++)
        exp[16*i +: 16] = mem[16'(b + 16'(i))];
      first = ld_vec;
      launch(st, b, v);
      wait_done(cyc, bcnt);
      if (st) begin
        chk_writes("rnd_st", b, v);
        chk("rnd_st_ldvec", ld_vec, first);
      end else begin
        chk("rnd_ld", ld_vec, exp);
      end
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
